// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit cores.
//   rx_state_t          : receiver state encoding
//   DEFAULT_CLK_PER_BIT : system clocks per bit (100 MHz / 115200 baud)
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for bringing asynchronous signals into the clk domain.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset, loads RESET_VAL into both flops
//   d    : asynchronous input
//   q    : synchronized output
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Both stages reset to the line's idle value so no false edge appears after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Request-driven 8N1 UART receiver. A one-cycle r_valid while idle arms the
// receiver for one byte; the byte is delivered with a one-cycle rx_done pulse.
// Ports:
//   clk     : system clock, rising edge
//   rstn    : asynchronous active-low reset
//   rxd     : asynchronous serial line, idle high, LSB first
//   r_valid : one-cycle receive request, honoured only while ready=1
//   ready   : high while idle
//   r_data  : last correctly framed byte, held until the next good frame
//   rx_done : one-cycle pulse, r_data valid in the same cycle
//   ferr    : one-cycle pulse on a stop-bit framing error
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       r_valid,
  output logic       ready,
  output logic [7:0] r_data,
  output logic       rx_done,
  output logic       ferr
);

  localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);

  rx_state_t   state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_next;
  logic        done_next, ferr_next;
  logic        rxd_s, rxd_prev;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rxd_s)
  );

  // Registered state, datapath and outputs; ready follows the next state so it
  // rises together with rx_done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      r_data    <= '0;
      rx_done   <= 1'b0;
      ferr      <= 1'b0;
      ready     <= 1'b1;
      rxd_prev  <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      r_data    <= data_next;
      rx_done   <= done_next;
      ferr      <= ferr_next;
      ready     <= (state_next == ST_IDLE);
      rxd_prev  <= rxd_s;
    end
  end

  // Next-state logic. Start detection needs a true 1->0 transition, so a line
  // that is already low when the receiver is armed is ignored until it rises.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    data_next    = r_data;
    done_next    = 1'b0;
    ferr_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (r_valid) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (rxd_prev && !rxd_s) begin
          cnt_next   = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          if (!rxd_s) begin
            cnt_next     = '0;
            bit_idx_next = '0;
            state_next   = ST_DATA;
          end else begin
            // Line went back high before mid start bit: glitch, re-arm
            state_next = ST_ARMED;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rxd_s;
          if (bit_idx == 3'd7) state_next = ST_STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rxd_s) begin
            data_next  = shift_reg;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            // Bad stop bit: the request stays pending
            ferr_next  = 1'b1;
            state_next = ST_ARMED;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Self-checking bench for uart_rx_core with CLK_PER_BIT=16. Expected bytes are
// queued when a frame that should be accepted is driven; a monitor pops and
// compares them when rx_done pulses.
module tb_uart_rx_core;

  localparam int BIT = 16;

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic       r_valid;
  logic       ready;
  logic [7:0] r_data;
  logic       rx_done;
  logic       ferr;

  int         errors = 0;
  int         checks = 0;
  int         done_count = 0;
  int         ferr_count = 0;
  int         ferr_expected = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       done_prev = 1'b0;
  logic       ferr_prev = 1'b0;

  uart_rx_core #(.CLK_PER_BIT(BIT)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .r_valid (r_valid),
    .ready   (ready),
    .r_data  (r_data),
    .rx_done (rx_done),
    .ferr    (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every pulse is checked against what the bench expects
  always @(negedge clk) begin
    if (rx_done) begin
      done_count = done_count + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpected_rx_done: r_data=%h, no byte expected", r_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (r_data !== e) begin
          errors = errors + 1;
          $display("[TB] FAIL rx_data: got %h expected %h", r_data, e);
        end
      end
      checks = checks + 1;
      if (ready !== 1'b1) begin
        errors = errors + 1;
        $display("[TB] FAIL ready_with_done: got %b expected 1", ready);
      end
      checks = checks + 1;
      if (ferr !== 1'b0 || done_prev !== 1'b0) begin
        errors = errors + 1;
        $display("[TB] FAIL done_pulse_shape: ferr=%b prev_done=%b expected 0 0", ferr, done_prev);
      end
    end
    if (ferr) begin
      ferr_count = ferr_count + 1;
      checks = checks + 1;
      if (ferr_expected == 0 || ferr_prev !== 1'b0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpected_ferr: pending=%0d prev_ferr=%b expected pending>0 prev 0", ferr_expected, ferr_prev);
      end else begin
        ferr_expected = ferr_expected - 1;
      end
    end
    done_prev = rx_done;
    ferr_prev = ferr;
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_request();
    r_valid = 1'b1;
    @(negedge clk);
    r_valid = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    rxd     = 1'b1;
    r_valid = 1'b0;
    idle(3);
    checks = checks + 1;
    if (ready !== 1'b1 || r_data !== 8'h00 || rx_done !== 1'b0 || ferr !== 1'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL reset_outputs: got ready=%b r_data=%h rx_done=%b ferr=%b expected 1 00 0 0",
               ready, r_data, rx_done, ferr);
    end
    rstn = 1'b1;
    idle(3);
    checks = checks + 1;
    if (ready !== 1'b1) begin
      errors = errors + 1;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", ready);
    end
  endtask

  task automatic test_good_frame();
    int d0;
    d0 = done_count;
    pulse_request();
    checks = checks + 1;
    if (ready !== 1'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL ready_when_armed: got %b expected 0", ready);
    end
    idle(4);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    for (int i = 0; i < 40 && done_count == d0; i++) @(negedge clk);
    checks = checks + 1;
    if (done_count !== d0 + 1) begin
      errors = errors + 1;
      $display("[TB] FAIL good_frame_pulses: got %0d expected %0d", done_count - d0, 1);
    end
    last_good = 8'hA5;
    checks = checks + 1;
    if (r_data !== 8'hA5 || ready !== 1'b1 || ferr !== 1'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL good_frame_state: got r_data=%h ready=%b ferr=%b expected a5 1 0", r_data, ready, ferr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    int d0;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    d0 = done_count;
    for (int k = 0; k < 2; k++) begin
      checks = checks + 1;
      if (ready !== 1'b1) begin
        errors = errors + 1;
        $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", k, ready);
      end
      pulse_request();
      exp_q.push_back(bytes[k]);
      send_frame(bytes[k], 1'b1);
      for (int i = 0; i < 40 && done_count == d0 + k; i++) @(negedge clk);
      checks = checks + 1;
      if (r_data !== bytes[k]) begin
        errors = errors + 1;
        $display("[TB] FAIL b2b_data_%0d: got %h expected %h", k, r_data, bytes[k]);
      end
    end
    last_good = 8'hFF;
    checks = checks + 1;
    if (done_count !== d0 + 2) begin
      errors = errors + 1;
      $display("[TB] FAIL b2b_pulses: got %0d expected %0d", done_count - d0, 2);
    end
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_count;
    f0 = ferr_count;
    pulse_request();
    idle(8);
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(3 * BIT);
    checks = checks + 1;
    if (done_count !== d0 || ferr_count !== f0 || ready !== 1'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL glitch_ignored: got done=%0d ferr=%0d ready=%b expected 0 0 0",
               done_count - d0, ferr_count - f0, ready);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    for (int i = 0; i < 40 && done_count == d0; i++) @(negedge clk);
    last_good = 8'h3C;
    checks = checks + 1;
    if (done_count !== d0 + 1 || r_data !== 8'h3C) begin
      errors = errors + 1;
      $display("[TB] FAIL glitch_next_frame: got pulses=%0d r_data=%h expected 1 3c", done_count - d0, r_data);
    end
  endtask

  task automatic test_framing_error();
    int d0, f0;
    d0 = done_count;
    f0 = ferr_count;
    pulse_request();
    idle(4);
    ferr_expected = ferr_expected + 1;
    send_frame(8'h5A, 1'b0);
    for (int i = 0; i < 40 && ferr_count == f0; i++) @(negedge clk);
    checks = checks + 1;
    if (ferr_count !== f0 + 1 || done_count !== d0) begin
      errors = errors + 1;
      $display("[TB] FAIL ferr_pulse: got ferr=%0d done=%0d expected 1 0", ferr_count - f0, done_count - d0);
    end
    checks = checks + 1;
    if (r_data !== last_good || ready !== 1'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL ferr_hold: got r_data=%h ready=%b expected %h 0", r_data, ready, last_good);
    end
    idle(BIT);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    for (int i = 0; i < 40 && done_count == d0; i++) @(negedge clk);
    last_good = 8'h11;
    checks = checks + 1;
    if (done_count !== d0 + 1 || r_data !== 8'h11) begin
      errors = errors + 1;
      $display("[TB] FAIL ferr_recovery: got pulses=%0d r_data=%h expected 1 11", done_count - d0, r_data);
    end
  endtask

  task automatic test_no_request();
    int d0;
    d0 = done_count;
    send_frame(8'h77, 1'b1);
    idle(2 * BIT);
    checks = checks + 1;
    if (done_count !== d0 || r_data !== last_good || ready !== 1'b1) begin
      errors = errors + 1;
      $display("[TB] FAIL no_request: got pulses=%0d r_data=%h ready=%b expected 0 %h 1",
               done_count - d0, r_data, ready, last_good);
    end
  endtask

  task automatic test_reset_mid_data();
    int d0, f0;
    d0 = done_count;
    f0 = ferr_count;
    pulse_request();
    idle(4);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        idle(BIT * 5 + 4);
        rstn = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (ready !== 1'b1 || r_data !== 8'h00 || rx_done !== 1'b0 || ferr !== 1'b0) begin
          errors = errors + 1;
          $display("[TB] FAIL midframe_reset: got ready=%b r_data=%h rx_done=%b ferr=%b expected 1 00 0 0",
                   ready, r_data, rx_done, ferr);
        end
        idle(2);
        rstn = 1'b1;
      end
    join
    last_good = 8'h00;
    idle(2 * BIT);
    checks = checks + 1;
    if (done_count !== d0 || ferr_count !== f0 || ready !== 1'b1 || r_data !== 8'h00) begin
      errors = errors + 1;
      $display("[TB] FAIL after_midframe_reset: got done=%0d ferr=%0d ready=%b r_data=%h expected 0 0 1 00",
               done_count - d0, ferr_count - f0, ready, r_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_no_request();
    test_reset_mid_data();
    checks = checks + 1;
    if (exp_q.size() != 0 || ferr_expected != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL scoreboard_drain: got %0d bytes %0d ferr pending expected 0 0",
               exp_q.size(), ferr_expected);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
